// File: rtl/mem_stage_access_unit_if.sv
// MEM-stage access bundle: EX/MEM request side, byte-wide data RAM side, MEM/WB result side.
// Purely signal grouping with no logic; the access unit uses the slave view.
// RAM read data is expected one cycle after the read strobe.
interface mem_stage_access_unit_if #(
  parameter int ADDR_W = 8
);
  // EX/MEM request
  logic              mem_read_enable_in;
  logic              mem_write_enable_in;
  logic              reg_write_enable_in;
  logic              size_byte_in;
  logic [31:0]       addr_in;
  logic [31:0]       store_data_in;
  logic [3:0]        rd_in;
  // Byte-wide data RAM port
  logic [ADDR_W-1:0] bmem_addr;
  logic [7:0]        bmem_wdata;
  logic              bmem_we;
  logic              bmem_re;
  logic [7:0]        bmem_rdata;
  // Pipeline control and MEM/WB result
  logic              stall;
  logic [31:0]       load_data_out;
  logic              load_valid;
  logic              reg_write_enable_out;
  logic [3:0]        rd_out;

  // Access unit view
  modport slave (
    input  mem_read_enable_in, mem_write_enable_in, reg_write_enable_in, size_byte_in,
    input  addr_in, store_data_in, rd_in, bmem_rdata,
    output bmem_addr, bmem_wdata, bmem_we, bmem_re,
    output stall, load_data_out, load_valid, reg_write_enable_out, rd_out
  );

  // Pipeline/RAM environment view
  modport master (
    output mem_read_enable_in, mem_write_enable_in, reg_write_enable_in, size_byte_in,
    output addr_in, store_data_in, rd_in, bmem_rdata,
    input  bmem_addr, bmem_wdata, bmem_we, bmem_re,
    input  stall, load_data_out, load_valid, reg_write_enable_out, rd_out
  );
endinterface

// File: rtl/mem_stage_access_unit.sv
// MEM-stage access unit: serialises byte/word loads and stores onto a byte-wide RAM port.
// Latency: STRB 2, STR 5, LDRB 3, LDR 6 cycles from request to DONE (stall held until DONE).
// Backpressure: stall is combinational (req & not DONE); upstream holds inputs while stalled.
module mem_stage_access_unit #(
  parameter int ADDR_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  mem_stage_access_unit_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR      = 3'd1,
    RD      = 3'd2,
    RD_LAST = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t            state_q;
  logic [1:0]        beat_q;
  logic              we_q;
  logic              re_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        wdata_q;
  logic [31:0]       load_data_q;
  logic              load_valid_q;

  logic              req;
  logic              last_beat;
  logic [1:0]        beat_sel_d;
  logic [ADDR_W-1:0] beat_addr_d;
  logic [7:0]        beat_wdata_d;

  assign req       = bus.mem_read_enable_in | bus.mem_write_enable_in;
  assign last_beat = bus.size_byte_in ? (beat_q == 2'd0) : (beat_q == 2'd3);

  // Address bits above the RAM width are intentionally ignored.
  if (ADDR_W < 32) begin : g_addr_hi
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.addr_in[31:ADDR_W];
  end

  // Address and write byte for the beat about to be issued (beat 0 from IDLE, else next beat).
  always_comb begin
    beat_sel_d = (state_q == IDLE) ? 2'd0 : beat_q + 2'd1;
    if (bus.size_byte_in) begin
      beat_addr_d  = bus.addr_in[ADDR_W-1:0];
      beat_wdata_d = bus.store_data_in[7:0];
    end else begin
      // Word accesses are forced to the aligned word; misalignment is not a fault.
      beat_addr_d  = {bus.addr_in[ADDR_W-1:2], beat_sel_d};
      beat_wdata_d = bus.store_data_in[{beat_sel_d, 3'b000} +: 8];
    end
  end

  // Access sequencer: strobes, address and write data are registered alongside the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      beat_q       <= 2'd0;
      we_q         <= 1'b0;
      re_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= 8'h00;
      load_data_q  <= 32'h0;
      load_valid_q <= 1'b0;
    end else begin
      we_q         <= 1'b0;
      re_q         <= 1'b0;
      load_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req) begin
            beat_q <= 2'd0;
            addr_q <= beat_addr_d;
            if (bus.mem_write_enable_in) begin
              // Write wins when both enables are set.
              state_q <= WR;
              we_q    <= 1'b1;
              wdata_q <= beat_wdata_d;
            end else begin
              // Clearing here gives byte loads their zero extension.
              state_q     <= RD;
              re_q        <= 1'b1;
              load_data_q <= 32'h0;
            end
          end
        end
        WR: begin
          if (last_beat) begin
            state_q <= DONE;
          end else begin
            beat_q  <= beat_sel_d;
            we_q    <= 1'b1;
            addr_q  <= beat_addr_d;
            wdata_q <= beat_wdata_d;
          end
        end
        RD: begin
          // Read data for the previous beat arrives this cycle.
          if (beat_q != 2'd0) begin
            load_data_q[{beat_q - 2'd1, 3'b000} +: 8] <= bus.bmem_rdata;
          end
          if (last_beat) begin
            state_q <= RD_LAST;
          end else begin
            beat_q <= beat_sel_d;
            re_q   <= 1'b1;
            addr_q <= beat_addr_d;
          end
        end
        RD_LAST: begin
          load_data_q[{beat_q, 3'b000} +: 8] <= bus.bmem_rdata;
          load_valid_q <= 1'b1;
          state_q      <= DONE;
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.bmem_addr            = addr_q;
  assign bus.bmem_wdata           = wdata_q;
  assign bus.bmem_we              = we_q;
  assign bus.bmem_re              = re_q;
  assign bus.stall                = req & (state_q != DONE);
  assign bus.load_data_out        = load_data_q;
  assign bus.load_valid           = load_valid_q;
  assign bus.reg_write_enable_out = bus.reg_write_enable_in & ~bus.stall;
  assign bus.rd_out               = bus.rd_in;

endmodule

// File: tb/tb_mem_stage_access_unit.sv
// Bench for mem_stage_access_unit: directed spec cases then random loads/stores.
// Expected RAM contents, load values and stall lengths come from a byte-array model.
// The RAM responder answers reads one cycle after the read strobe.
module tb_mem_stage_access_unit;

  logic clk = 1'b0;
  logic reset;
  logic init_en;

  always #5 clk = ~clk;

  mem_stage_access_unit_if #(.ADDR_W(8)) bus ();

  mem_stage_access_unit #(.ADDR_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Byte RAM with registered read data; init_en loads a known pattern.
  logic [7:0] ram [256];
  logic [7:0] rdata_q;
  logic [7:0] exp_mem [256];

  // RAM responder.
  always @(posedge clk) begin
    if (init_en) begin
      for (int i = 0; i < 256; i++) ram[i] <= 8'(i) ^ 8'h5A;
    end else if (bus.bmem_we) begin
      ram[bus.bmem_addr] <= bus.bmem_wdata;
    end
    if (bus.bmem_re) rdata_q <= ram[bus.bmem_addr];
  end
  assign bus.bmem_rdata = rdata_q;

  // Running strobe totals, sampled mid-cycle.
  int we_tot = 0, re_tot = 0, both_tot = 0;
  always @(negedge clk) begin
    if (bus.bmem_we) we_tot++;
    if (bus.bmem_re) re_tot++;
    if (bus.bmem_we && bus.bmem_re) both_tot++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive_idle();
    bus.mem_read_enable_in  = 1'b0;
    bus.mem_write_enable_in = 1'b0;
    bus.reg_write_enable_in = 1'b0;
    bus.size_byte_in        = 1'b0;
    bus.addr_in             = 32'h0;
    bus.store_data_in       = 32'h0;
    bus.rd_in               = 4'h0;
  endtask

  task automatic drive_op(input logic rd_en, input logic wr_en, input logic regw,
                          input logic sz_byte, input logic [31:0] addr,
                          input logic [31:0] data, input logic [3:0] rd);
    bus.mem_read_enable_in  = rd_en;
    bus.mem_write_enable_in = wr_en;
    bus.reg_write_enable_in = regw;
    bus.size_byte_in        = sz_byte;
    bus.addr_in             = addr;
    bus.store_data_in       = data;
    bus.rd_in               = rd;
  endtask

  // RAM byte touched by byte k of an access (word accesses use the aligned word).
  function automatic int byte_addr(input logic sz_byte, input logic [31:0] addr, input int k);
    int a;
    a = int'(addr % 256);
    return sz_byte ? a : (a - (a % 4) + k);
  endfunction

  // One complete pipeline instruction: drive, wait out the stall, check the result.
  task automatic run_op(input string tag, input logic rd_en, input logic wr_en,
                        input logic regw, input logic sz_byte, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] rd);
    int n, cycles, rwe_leak, lv_leak, we0, re0, both0;
    logic is_store, is_load;
    logic [31:0] exp_ld;
    n        = sz_byte ? 1 : 4;
    is_store = wr_en;
    is_load  = rd_en & ~wr_en;
    exp_ld   = 32'h0;
    for (int k = 0; k < n; k++)
      exp_ld = exp_ld | (32'(exp_mem[byte_addr(sz_byte, addr, k)]) << (8 * k));

    @(negedge clk);
    we0 = we_tot; re0 = re_tot; both0 = both_tot;
    drive_op(rd_en, wr_en, regw, sz_byte, addr, data, rd);
    #1;
    cycles = 0; rwe_leak = 0; lv_leak = 0;
    while (bus.stall && cycles < 20) begin
      cycles++;
      if (bus.reg_write_enable_out) rwe_leak++;
      if (bus.load_valid) lv_leak++;
      @(negedge clk);
      #1;
    end
    check({tag, " stall_cycles"}, 32'(cycles),
          32'(is_store ? n + 1 : (is_load ? n + 2 : 0)));
    check({tag, " load_valid"}, {31'h0, bus.load_valid}, {31'h0, is_load});
    if (is_load) check({tag, " load_data"}, bus.load_data_out, exp_ld);
    check({tag, " reg_we_out"}, {31'h0, bus.reg_write_enable_out}, {31'h0, regw});
    check({tag, " rd_out"}, {28'h0, bus.rd_out}, {28'h0, rd});
    check({tag, " reg_we_during_stall"}, 32'(rwe_leak), 32'h0);
    check({tag, " valid_during_stall"}, 32'(lv_leak), 32'h0);

    if (is_store)
      for (int k = 0; k < n; k++)
        exp_mem[byte_addr(sz_byte, addr, k)] = data[8*k +: 8];

    @(negedge clk);
    drive_idle();
    check({tag, " we_beats"}, 32'(we_tot - we0), 32'(is_store ? n : 0));
    check({tag, " re_beats"}, 32'(re_tot - re0), 32'(is_load ? n : 0));
    check({tag, " we_re_overlap"}, 32'(both_tot - both0), 32'h0);
  endtask

  task automatic check_ram(input int a);
    check($sformatf("ram[0x%02h]", a), {24'h0, ram[a]}, {24'h0, exp_mem[a]});
  endtask

  initial begin
    logic [1:0] kind;
    for (int i = 0; i < 256; i++) exp_mem[i] = 8'(i) ^ 8'h5A;
    drive_idle();
    reset   = 1'b1;
    init_en = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check("reset load_data", bus.load_data_out, 32'h0);
    check("reset load_valid", {31'h0, bus.load_valid}, 32'h0);
    check("reset we", {31'h0, bus.bmem_we}, 32'h0);
    check("reset re", {31'h0, bus.bmem_re}, 32'h0);
    check("reset stall", {31'h0, bus.stall}, 32'h0);
    reset   = 1'b0;
    init_en = 1'b0;

    // Word store then overlapping word load (misaligned address reads the aligned word).
    run_op("STR 0x10", 1'b0, 1'b1, 1'b0, 1'b0, 32'h10, 32'hA1B2C3D4, 4'd0);
    check("STR byte 0x10", {24'h0, ram[8'h10]}, 32'hD4);
    check("STR byte 0x13", {24'h0, ram[8'h13]}, 32'hA1);
    run_op("LDR 0x12", 1'b1, 1'b0, 1'b1, 1'b0, 32'h12, 32'h0, 4'd3);
    check("LDR value", bus.load_data_out, 32'hA1B2C3D4);

    // Byte store/load with neighbours untouched.
    run_op("STRB 0x21", 1'b0, 1'b1, 1'b0, 1'b1, 32'h21, 32'h000000EE, 4'd0);
    run_op("LDRB 0x21", 1'b1, 1'b0, 1'b1, 1'b1, 32'h21, 32'h0, 4'd7);
    check("LDRB value", bus.load_data_out, 32'h000000EE);
    check_ram(8'h20);
    check_ram(8'h22);

    // Non-memory op passes straight through.
    run_op("ALU rd5", 1'b0, 1'b0, 1'b1, 1'b0, 32'h55, 32'h0, 4'd5);

    // Both enables: write wins, no reads, no load_valid.
    run_op("RW 0x30", 1'b1, 1'b1, 1'b0, 1'b0, 32'h30, 32'h11223344, 4'd0);
    for (int a = 8'h30; a < 8'h34; a++) check_ram(a);

    // Reset after two beats of a word store: only the first two bytes land.
    @(negedge clk);
    drive_op(1'b0, 1'b1, 1'b0, 1'b0, 32'h40, 32'hCAFEBABE, 4'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1;
    check("midreset we", {31'h0, bus.bmem_we}, 32'h0);
    check("midreset re", {31'h0, bus.bmem_re}, 32'h0);
    check("midreset stall_in_idle", {31'h0, bus.stall}, 32'h1);
    drive_idle();
    reset = 1'b0;
    #1;
    check("midreset stall_idle", {31'h0, bus.stall}, 32'h0);
    exp_mem[8'h40] = 8'hBE;
    exp_mem[8'h41] = 8'hBA;
    for (int a = 8'h40; a < 8'h44; a++) check_ram(a);

    // Random mix of loads, stores, dual-enable and non-memory ops.
    for (int i = 0; i < 40; i++) begin
      kind = 2'($urandom_range(0, 3));
      run_op($sformatf("rnd%0d", i),
             (kind == 2'd0) || (kind == 2'd2),
             (kind == 2'd1) || (kind == 2'd2),
             1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)),
             $urandom, $urandom, 4'($urandom_range(0, 15)));
    end

    @(negedge clk);
    for (int a = 0; a < 256; a++) check_ram(a);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
